iter_div_axis: RTL and testbench



---
 rtl/iter_div_axis.sv | 149 ++++++++++++++
 tb/tb_iter_div_axis.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_axis.sv
// Iterative radix-2 restoring 32-bit divider with stream-style operand and result channels.
// Optional macro DIV_EARLY_TERM_EN: one-cycle finish when divisor==0 or |dividend| < |divisor|.

module iter_div_axis #(
    parameter int SIGNED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    output logic        m_axis_dout_tvalid,
    output logic [63:0] m_axis_dout_tdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        dout_valid_q, dout_valid_d;
    logic [63:0] dout_data_q, dout_data_d;

    logic        accept;
    logic        early;
    logic        dnd_neg, dvs_neg;
    logic [31:0] dnd_mag, dvs_mag;
    logic [32:0] shifted;
    logic [31:0] trial;
    logic        ge;
    logic [31:0] quo_fix, rem_fix;

    // Operand magnitudes; -2^31 negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        dnd_neg = (SIGNED != 0) && s_axis_dividend_tdata[31];
        dvs_neg = (SIGNED != 0) && s_axis_divisor_tdata[31];
        dnd_mag = dnd_neg ? (~s_axis_dividend_tdata + 32'd1) : s_axis_dividend_tdata;
        dvs_mag = dvs_neg ? (~s_axis_divisor_tdata + 32'd1) : s_axis_divisor_tdata;
    end

`ifdef DIV_EARLY_TERM_EN
    assign early = (dvs_mag == 32'd0) || (dnd_mag < dvs_mag);
`else
    assign early = 1'b0;
`endif

    assign accept = (state_q == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        ge      = (shifted >= {1'b0, dvsr_q});
        trial   = shifted[31:0] - dvsr_q;
        quo_fix = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_comb begin
        state_d                = state_q;
        count_d                = count_q;
        rem_d                  = rem_q;
        quo_d                  = quo_q;
        dvsr_d                 = dvsr_q;
        quo_neg_d              = quo_neg_q;
        rem_neg_d              = rem_neg_q;
        dout_valid_d           = 1'b0;
        dout_data_d            = dout_data_q;
        s_axis_dividend_tready = 1'b0;
        s_axis_divisor_tready  = 1'b0;

        case (state_q)
            IDLE: begin
                s_axis_dividend_tready = 1'b1;
                s_axis_divisor_tready  = 1'b1;
                if (accept) begin
                    dvsr_d    = dvs_mag;
                    quo_neg_d = dnd_neg ^ dvs_neg;
                    rem_neg_d = dnd_neg;
                    count_d   = 5'd0;
                    if (early) begin
                        // Same values the full iteration would converge to.
                        quo_d   = (dvs_mag == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                        rem_d   = dnd_mag;
                        state_d = DONE;
                    end else begin
                        quo_d   = dnd_mag;
                        rem_d   = 32'd0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d   = ge ? trial : shifted[31:0];
                quo_d   = {quo_q[30:0], ge};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dout_valid_d = 1'b1;
                dout_data_d  = {quo_fix, rem_fix};
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 5'd0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            dvsr_q       <= 32'd0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvsr_q       <= dvsr_d;
            quo_neg_q    <= quo_neg_d;
            rem_neg_q    <= rem_neg_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
        end
    end

    assign m_axis_dout_tvalid = dout_valid_q;
    assign m_axis_dout_tdata  = dout_data_q;

endmodule

// File: tb/tb_iter_div_axis.sv
// Bench for iter_div_axis: unsigned and signed instances share operand channels;
// results are checked against a table and a plain-arithmetic reference model.

module tb_iter_div_axis;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        dividend_tvalid, divisor_tvalid;
    logic [31:0] dividend_tdata, divisor_tdata;
    logic [1:0]  dnd_rdy, dvs_rdy, dout_valid;
    logic [63:0] dout_data_u, dout_data_s;

    iter_div_axis #(.SIGNED(0)) u_divu (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tvalid (dividend_tvalid),
        .s_axis_dividend_tready (dnd_rdy[0]),
        .s_axis_dividend_tdata  (dividend_tdata),
        .s_axis_divisor_tvalid  (divisor_tvalid),
        .s_axis_divisor_tready  (dvs_rdy[0]),
        .s_axis_divisor_tdata   (divisor_tdata),
        .m_axis_dout_tvalid     (dout_valid[0]),
        .m_axis_dout_tdata      (dout_data_u)
    );

    iter_div_axis #(.SIGNED(1)) u_div (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tvalid (dividend_tvalid),
        .s_axis_dividend_tready (dnd_rdy[1]),
        .s_axis_dividend_tdata  (dividend_tdata),
        .s_axis_divisor_tvalid  (divisor_tvalid),
        .s_axis_divisor_tready  (dvs_rdy[1]),
        .s_axis_divisor_tdata   (divisor_tdata),
        .m_axis_dout_tvalid     (dout_valid[1]),
        .m_axis_dout_tdata      (dout_data_s)
    );

`ifdef DIV_EARLY_TERM_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_u;
        logic [63:0] exp_s;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          got_lat [2];
    int          got_cnt [2];
    int          rdy_bad [2];
    logic [63:0] got_data [2];

    // Reference: 64-bit integer division truncates toward zero; x/0 has fixed results.
    function automatic logic [63:0] model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (sb == 0) begin
            q = (sa < 0) ? 64'sd1 : 64'sh0000_0000_FFFF_FFFF;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {q[31:0], r[31:0]};
    endfunction

    function automatic int model_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        return (EARLY_EN && (mb == 0 || ma < mb)) ? 1 : 33;
    endfunction

    function automatic logic [63:0] dout_of(input int i);
        return (i == 0) ? dout_data_u : dout_data_s;
    endfunction

    function automatic string sfx(input int i);
        return (i == 0) ? "divu" : "div";
    endfunction

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Watch both instances for 41 cycles after a handshake edge.
    task automatic collect(input int lat0, input int lat1);
        int lat [2];
        lat[0] = lat0;
        lat[1] = lat1;
        for (int i = 0; i < 2; i++) begin
            got_lat[i]  = -1;
            got_cnt[i]  = 0;
            rdy_bad[i]  = 0;
            got_data[i] = '0;
        end
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 2; i++) begin
                if (dout_valid[i]) begin
                    if (got_cnt[i] == 0) begin
                        got_lat[i]  = k;
                        got_data[i] = dout_of(i);
                    end
                    got_cnt[i]++;
                end
                if (k < lat[i] && (dnd_rdy[i] || dvs_rdy[i])) rdy_bad[i]++;
                if (k == lat[i] && !(dnd_rdy[i] && dvs_rdy[i])) rdy_bad[i]++;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_u, input logic [63:0] exp_s);
        logic [63:0] exp [2];
        int          lat [2];
        exp[0] = exp_u;
        exp[1] = exp_s;
        lat[0] = model_lat(1'b0, a, b);
        lat[1] = model_lat(1'b1, a, b);
        $display("op %s a=%h b=%h expect divu=%h div=%h", name, a, b, exp_u, exp_s);
        dividend_tdata  = a;
        divisor_tdata   = b;
        dividend_tvalid = 1'b1;
        divisor_tvalid  = 1'b1;
        @(posedge clk);
        #1;
        dividend_tvalid = 1'b0;
        divisor_tvalid  = 1'b0;
        collect(lat[0], lat[1]);
        for (int i = 0; i < 2; i++) begin
            chk64({name, ".", sfx(i), ".data"}, got_data[i], exp[i]);
            chki({name, ".", sfx(i), ".latency"}, got_lat[i], lat[i]);
            chki({name, ".", sfx(i), ".pulses"}, got_cnt[i], 1);
            chki({name, ".", sfx(i), ".tready_errs"}, rdy_bad[i], 0);
        end
    endtask

    vec_t tbl [12];

    initial begin
        int          cnt [2];
        int          bad [2];
        int          lat1 [2];
        int          lat2 [2];
        logic [63:0] d1 [2];
        logic [63:0] d2 [2];
        logic [31:0] ra, rb;

        tbl[0]  = '{32'd100,        32'd7,          64'h0000000E_00000002, 64'h0000000E_00000002};
        tbl[1]  = '{32'hFFFF_FFF9,  32'd2,          64'h7FFFFFFC_00000001, 64'hFFFFFFFD_FFFFFFFF};
        tbl[2]  = '{32'd7,          32'hFFFF_FFFE,  64'h00000000_00000007, 64'hFFFFFFFD_00000001};
        tbl[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 64'h80000000_00000000};
        tbl[4]  = '{32'hFFFF_FFFF,  32'd1,          64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
        tbl[5]  = '{32'd5,          32'd0,          64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005};
        tbl[6]  = '{32'hFFFF_FFFB,  32'd0,          64'hFFFFFFFF_FFFFFFFB, 64'h00000001_FFFFFFFB};
        tbl[7]  = '{32'd0,          32'd0,          64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
        tbl[8]  = '{32'h8000_0000,  32'd0,          64'hFFFFFFFF_80000000, 64'h00000001_80000000};
        tbl[9]  = '{32'd3,          32'd9,          64'h00000000_00000003, 64'h00000000_00000003};
        tbl[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000001_00000000, 64'h00000001_00000000};
        tbl[11] = '{32'h8000_0000,  32'h8000_0000,  64'h00000001_00000000, 64'h00000001_00000000};

        reset           = 1'b1;
        dividend_tvalid = 1'b0;
        divisor_tvalid  = 1'b0;
        dividend_tdata  = '0;
        divisor_tdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("op reset");
        for (int i = 0; i < 2; i++) begin
            chki({"reset.", sfx(i), ".tvalid"}, int'(dout_valid[i]), 0);
            chk64({"reset.", sfx(i), ".tdata"}, dout_of(i), 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chki({"idle.", sfx(i), ".tready"}, int'(dnd_rdy[i] && dvs_rdy[i]), 1);
        end

        for (int j = 0; j < 12; j++) begin
            run_op($sformatf("vec%0d", j), tbl[j].a, tbl[j].b, tbl[j].exp_u, tbl[j].exp_s);
        end

        // Only the dividend channel valid: nothing may be accepted.
        $display("op hs-dividend-only a=00000032");
        dividend_tdata  = 32'd50;
        divisor_tdata   = 32'd5;
        dividend_tvalid = 1'b1;
        divisor_tvalid  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            bad[i] = 0;
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (dout_valid[i]) cnt[i]++;
                if (!(dnd_rdy[i] && dvs_rdy[i])) bad[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chki({"hs.", sfx(i), ".pulses"}, cnt[i], 0);
            chki({"hs.", sfx(i), ".not_ready"}, bad[i], 0);
        end
        run_op("hs-accept", 32'd50, 32'd5, 64'h0000000A_00000000, 64'h0000000A_00000000);

        // Back-to-back: master holds valid, second accept lands on edge 34.
        $display("op back-to-back 100/7 then 1000/10");
        dividend_tdata  = 32'd100;
        divisor_tdata   = 32'd7;
        dividend_tvalid = 1'b1;
        divisor_tvalid  = 1'b1;
        @(posedge clk);
        #1;
        dividend_tdata = 32'd1000;
        divisor_tdata  = 32'd10;
        for (int i = 0; i < 2; i++) begin
            cnt[i]  = 0;
            lat1[i] = -1;
            lat2[i] = -1;
            d1[i]   = '0;
            d2[i]   = '0;
        end
        for (int k = 1; k <= 75; k++) begin
            @(posedge clk);
            #1;
            if (k == 34) begin
                dividend_tvalid = 1'b0;
                divisor_tvalid  = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (dout_valid[i]) begin
                    if (cnt[i] == 0) begin
                        lat1[i] = k;
                        d1[i]   = dout_of(i);
                    end else if (cnt[i] == 1) begin
                        lat2[i] = k;
                        d2[i]   = dout_of(i);
                    end
                    cnt[i]++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            chki({"b2b.", sfx(i), ".lat1"}, lat1[i], 33);
            chk64({"b2b.", sfx(i), ".data1"}, d1[i], 64'h0000000E_00000002);
            chki({"b2b.", sfx(i), ".lat2"}, lat2[i], 67);
            chk64({"b2b.", sfx(i), ".data2"}, d2[i], 64'h00000064_00000000);
            chki({"b2b.", sfx(i), ".pulses"}, cnt[i], 2);
        end

        // Asynchronous reset mid-division clears the held result and drops the operation.
        $display("op reset-mid a=00000064 b=00000007");
        dividend_tdata  = 32'd100;
        divisor_tdata   = 32'd7;
        dividend_tvalid = 1'b1;
        divisor_tvalid  = 1'b1;
        @(posedge clk);
        #1;
        dividend_tvalid = 1'b0;
        divisor_tvalid  = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chki({"rstmid.", sfx(i), ".tvalid"}, int'(dout_valid[i]), 0);
            chk64({"rstmid.", sfx(i), ".tdata"}, dout_of(i), 64'd0);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) cnt[i] = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (dout_valid[i]) cnt[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chki({"rstmid.", sfx(i), ".pulses"}, cnt[i], 0);
        end
        run_op("post-rst", 32'd9, 32'd3, 64'h00000003_00000000, 64'h00000003_00000000);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFF_FFFF;
                3: rb = ra >> $urandom_range(0, 31);
                4: begin
                    rb = $urandom;
                    ra = ra >> $urandom_range(16, 31);
                end
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", n), ra, rb, model_div(1'b0, ra, rb), model_div(1'b1, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
